// File: rtl/lcd_pkg.sv
// Shared definitions for the streaming HD44780 writer: FSM encoding,
// LCD command opcodes, register-select values and DDRAM row bases.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_SETTLE = 3'd4
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam logic [7:0] ROW_BASE0 = 8'h00;
    localparam logic [7:0] ROW_BASE1 = 8'h40;
    localparam logic [7:0] ROW_BASE2 = 8'h14;
    localparam logic [7:0] ROW_BASE3 = 8'h54;

    localparam logic RS_DATA = 1'b1;
    localparam logic RS_CMD  = 1'b0;

    function automatic logic [7:0] row_base(input logic [1:0] row);
        logic [7:0] base;
        case (row)
            2'd0:    base = ROW_BASE0;
            2'd1:    base = ROW_BASE1;
            2'd2:    base = ROW_BASE2;
            default: base = ROW_BASE3;
        endcase
        return base;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO of {rs, data} entries with first-word fall-through read.
// Pushes while full and pops while empty are ignored.
module lcd_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rptr[AW-1:0]];

    // Read/write pointers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage array
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/lcd_stream_writer.sv
// Streams buffered data/command bytes onto HD44780 pins with programmable
// setup/enable/hold/settle timing, tracking the cursor and inserting wraps.
module lcd_stream_writer
    import lcd_pkg::*;
#(
    parameter int COLS          = 16,
    parameter int ROWS          = 2,
    parameter int FIFO_DEPTH    = 8,
    parameter int SETUP_CYC     = 1,
    parameter int E_HIGH_CYC    = 2,
    parameter int HOLD_CYC      = 1,
    parameter int WAIT_DATA_CYC = 2,
    parameter int WAIT_CMD_CYC  = 8,
    localparam int CW           = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk_1024,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic          in_rs,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic [7:0]    data_lcd,
    output logic          E_lcd,
    output logic          RW_lcd,
    output logic          RS_lcd,
    output logic          busy,
    output logic [CW-1:0] cur_col,
    output logic [1:0]    cur_row
);
    localparam logic [7:0]    L_SETUP  = 8'(SETUP_CYC - 1);
    localparam logic [7:0]    L_STROBE = 8'(E_HIGH_CYC - 1);
    localparam logic [7:0]    L_HOLD   = 8'(HOLD_CYC - 1);
    localparam logic [7:0]    L_WDATA  = 8'(WAIT_DATA_CYC - 1);
    localparam logic [7:0]    L_WCMD   = 8'(WAIT_CMD_CYC - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
    localparam logic [1:0]    LAST_ROW = 2'(ROWS - 1);

    lcd_state_e    r_state;
    lcd_state_e    w_next_state;
    logic [7:0]    r_cnt;
    logic [7:0]    w_limit;
    logic          w_cnt_done;
    logic          w_load;
    logic          w_fifo_pop;
    logic          w_enter_settle;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [8:0]    w_fifo_dout;
    logic          r_cur_rs;
    logic [7:0]    r_cur_data;
    logic          r_is_wrap;
    logic          r_wrap_pending;
    logic [CW-1:0] r_col;
    logic [1:0]    r_row;
    logic          r_e;
    logic          r_rs;
    logic [7:0]    r_data;

    lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
        .i_clk   (clk_1024),
        .i_rst_n (reset_n),
        .i_push  (in_valid),
        .i_din   ({in_rs, in_data}),
        .i_pop   (w_fifo_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign in_ready = !w_fifo_full;
    assign busy     = !w_fifo_empty || (r_state != ST_IDLE) || r_wrap_pending;
    assign E_lcd    = r_e;
    assign RS_lcd   = r_rs;
    assign data_lcd = r_data;
    assign RW_lcd   = 1'b0;
    assign cur_col  = r_col;
    assign cur_row  = r_row;

    // State register and per-state cycle counter
    always_ff @(posedge clk_1024) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= (w_next_state != r_state) ? 8'd0 : r_cnt + 8'd1;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_wrap_pending || !w_fifo_empty) begin
                    w_next_state = ST_SETUP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SETUP:  w_next_state = w_cnt_done ? ST_STROBE : ST_SETUP;
            ST_STROBE: w_next_state = w_cnt_done ? ST_HOLD   : ST_STROBE;
            ST_HOLD:   w_next_state = w_cnt_done ? ST_SETTLE : ST_HOLD;
            ST_SETTLE: w_next_state = w_cnt_done ? ST_IDLE   : ST_SETTLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Control decodes: phase length, write load, FIFO pop, cursor update
    always_comb begin
        w_limit = 8'd0;
        case (r_state)
            ST_SETUP:  w_limit = L_SETUP;
            ST_STROBE: w_limit = L_STROBE;
            ST_HOLD:   w_limit = L_HOLD;
            ST_SETTLE: w_limit = r_cur_rs ? L_WDATA : L_WCMD;
            default:   w_limit = 8'd0;
        endcase
        w_cnt_done     = (r_cnt == w_limit);
        w_load         = (r_state == ST_IDLE) && (r_wrap_pending || !w_fifo_empty);
        w_fifo_pop     = w_load && !r_wrap_pending;
        w_enter_settle = (r_state == ST_HOLD) && w_cnt_done;
    end

    // Write latch and pin registers; pins trail the latch by one cycle so E
    // rises after the full setup time
    always_ff @(posedge clk_1024) begin
        if (!reset_n) begin
            r_cur_rs   <= RS_DATA;
            r_cur_data <= 8'h00;
            r_is_wrap  <= 1'b0;
            r_e        <= 1'b0;
            r_rs       <= RS_DATA;
            r_data     <= 8'h00;
        end else begin
            if (w_load) begin
                if (r_wrap_pending) begin
                    r_cur_rs   <= RS_CMD;
                    r_cur_data <= CMD_SET_DDRAM | row_base(r_row);
                    r_is_wrap  <= 1'b1;
                end else begin
                    r_cur_rs   <= w_fifo_dout[8];
                    r_cur_data <= w_fifo_dout[7:0];
                    r_is_wrap  <= 1'b0;
                end
            end
            r_e    <= (r_state == ST_STROBE);
            r_rs   <= r_cur_rs;
            r_data <= r_cur_data;
        end
    end

    // Cursor tracking, updated as each write enters its settle phase
    always_ff @(posedge clk_1024) begin
        if (!reset_n) begin
            r_col          <= '0;
            r_row          <= 2'd0;
            r_wrap_pending <= 1'b0;
        end else if (w_enter_settle) begin
            if (r_is_wrap) begin
                r_wrap_pending <= 1'b0;
            end else if (r_cur_rs == RS_DATA) begin
                if (r_col == LAST_COL) begin
                    r_col          <= '0;
                    r_row          <= (r_row == LAST_ROW) ? 2'd0 : r_row + 2'd1;
                    r_wrap_pending <= 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else if ((r_cur_data == CMD_CLEAR) || (r_cur_data == CMD_HOME)) begin
                r_col          <= '0;
                r_row          <= 2'd0;
                r_wrap_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_stream_writer.sv
// Self-checking bench: pin-timing vector table, directed corner sequences and
// a randomized byte stream compared against a write-sequence reference model.
module tb_lcd_stream_writer;
    localparam int COLS   = 16;
    localparam int ROWS   = 2;
    localparam int E_HIGH = 2;

    logic       clk_1024 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_rs    = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       in_ready;
    logic [7:0] data_lcd;
    logic       E_lcd, RW_lcd, RS_lcd, busy;
    logic [3:0] cur_col;
    logic [1:0] cur_row;

    lcd_stream_writer #(
        .COLS(COLS), .ROWS(ROWS), .FIFO_DEPTH(8), .SETUP_CYC(1), .E_HIGH_CYC(E_HIGH),
        .HOLD_CYC(1), .WAIT_DATA_CYC(2), .WAIT_CMD_CYC(8)
    ) dut (
        .clk_1024(clk_1024), .reset_n(reset_n), .in_valid(in_valid), .in_rs(in_rs),
        .in_data(in_data), .in_ready(in_ready), .data_lcd(data_lcd), .E_lcd(E_lcd),
        .RW_lcd(RW_lcd), .RS_lcd(RS_lcd), .busy(busy), .cur_col(cur_col), .cur_row(cur_row)
    );

    always #5 clk_1024 = ~clk_1024;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [8:0] q_exp[$];
    logic [8:0] q_obs[$];
    int         m_col = 0;
    int         m_row = 0;
    logic       mon_en = 1'b0;
    int         row_base_tab[4] = '{32'h00, 32'h40, 32'h14, 32'h54};

    typedef struct {
        logic       e;
        logic       rs;
        logic [7:0] data;
        logic       busy;
        logic [3:0] col;
    } vec_t;
    vec_t tv[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the ordered LCD writes implied by the accepted bytes.
    task automatic model_accept(input logic rs, input logic [7:0] d);
        q_exp.push_back({rs, d});
        if (rs) begin
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
                q_exp.push_back({1'b0, 8'h80 | 8'(row_base_tab[m_row])});
            end
        end else if (d == 8'h01 || d == 8'h02) begin
            m_col = 0;
            m_row = 0;
        end
    endtask

    // Pin monitor: logs each strobed write and checks pulse width and hold.
    initial begin
        logic       prev_e = 1'b0;
        int         e_len = 0;
        logic [8:0] rise_val = '0;
        forever begin
            @(negedge clk_1024);
            if (E_lcd && !prev_e) begin
                q_obs.push_back({RS_lcd, data_lcd});
                rise_val = {RS_lcd, data_lcd};
                e_len = 1;
                chk("rw_low", {31'd0, RW_lcd}, 32'd0);
            end else if (E_lcd) begin
                e_len++;
            end
            if (!E_lcd && prev_e && mon_en) begin
                chk("e_width", e_len, E_HIGH);
                chk("hold_rs_data", {23'd0, RS_lcd, data_lcd}, {23'd0, rise_val});
            end
            prev_e = E_lcd;
        end
    end

    task automatic do_reset();
        mon_en   = 1'b0;
        in_valid = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(negedge clk_1024);
        reset_n = 1'b1;
        q_exp.delete();
        q_obs.delete();
        m_col  = 0;
        m_row  = 0;
        mon_en = 1'b1;
    endtask

    task automatic push(input logic rs, input logic [7:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        while (!in_ready && t < 500) begin
            @(negedge clk_1024);
            t++;
        end
        chk("push_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk_1024);
        in_valid = 1'b0;
        if (t < 500) model_accept(rs, d);
    endtask

    task automatic offer(input logic rs, input logic [7:0] d, output logic acc);
        in_valid = 1'b1;
        in_rs    = rs;
        in_data  = d;
        acc      = in_ready;
        @(negedge clk_1024);
        in_valid = 1'b0;
        if (acc) model_accept(rs, d);
    endtask

    task automatic drain_and_compare(input string tag);
        int t = 0;
        int n;
        while (busy && t < 3000) begin
            @(negedge clk_1024);
            t++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_nwrites"}, q_obs.size(), q_exp.size());
        n = (q_obs.size() < q_exp.size()) ? q_obs.size() : q_exp.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_write"}, {23'd0, q_obs[i]}, {23'd0, q_exp[i]});
        end
        chk({tag, "_col"}, {28'd0, cur_col}, m_col);
        chk({tag, "_row"}, {30'd0, cur_row}, m_row);
        q_obs.delete();
        q_exp.delete();
    endtask

    // Cycles from the E falling sample until busy drops.
    task automatic measure_settle(input logic rs, input logic [7:0] d, output int n);
        int t = 0;
        push(rs, d);
        while (!E_lcd && t < 50) begin @(negedge clk_1024); t++; end
        while (E_lcd && t < 100) begin @(negedge clk_1024); t++; end
        n = 0;
        while (busy && n < 100) begin @(negedge clk_1024); n++; end
    endtask

    initial begin
        logic acc;
        int   n;
        logic [7:0] cmds[4] = '{8'h01, 8'h02, 8'h06, 8'h0C};

        tv[0] = '{1'b0, 1'b1, 8'h00, 1'b1, 4'd0};
        tv[1] = '{1'b0, 1'b1, 8'h00, 1'b1, 4'd0};
        tv[2] = '{1'b0, 1'b1, 8'h41, 1'b1, 4'd0};
        tv[3] = '{1'b1, 1'b1, 8'h41, 1'b1, 4'd0};
        tv[4] = '{1'b1, 1'b1, 8'h41, 1'b1, 4'd0};
        tv[5] = '{1'b0, 1'b1, 8'h41, 1'b1, 4'd1};
        tv[6] = '{1'b0, 1'b1, 8'h41, 1'b1, 4'd1};
        tv[7] = '{1'b0, 1'b1, 8'h41, 1'b0, 4'd1};
        tv[8] = '{1'b0, 1'b1, 8'h41, 1'b0, 4'd1};

        // Reset state
        do_reset();
        chk("rst_e", {31'd0, E_lcd}, 32'd0);
        chk("rst_rw", {31'd0, RW_lcd}, 32'd0);
        chk("rst_rs", {31'd0, RS_lcd}, 32'd1);
        chk("rst_data", {24'd0, data_lcd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_col", {28'd0, cur_col}, 32'd0);
        chk("rst_row", {30'd0, cur_row}, 32'd0);

        // Single 'A' write, cycle-by-cycle pin timing from the acceptance edge
        in_valid = 1'b1; in_rs = 1'b1; in_data = 8'h41;
        @(negedge clk_1024);
        in_valid = 1'b0;
        model_accept(1'b1, 8'h41);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) @(negedge clk_1024);
            chk($sformatf("tv%0d_e", k), {31'd0, E_lcd}, {31'd0, tv[k].e});
            chk($sformatf("tv%0d_rs", k), {31'd0, RS_lcd}, {31'd0, tv[k].rs});
            chk($sformatf("tv%0d_data", k), {24'd0, data_lcd}, {24'd0, tv[k].data});
            chk($sformatf("tv%0d_busy", k), {31'd0, busy}, {31'd0, tv[k].busy});
            chk($sformatf("tv%0d_col", k), {28'd0, cur_col}, {28'd0, tv[k].col});
        end
        drain_and_compare("single");
        measure_settle(1'b1, 8'h42, n);
        chk("settle_data", n, 2);
        drain_and_compare("single2");

        // 16 characters then a 17th: wrap to row 1 inserted in between
        do_reset();
        for (int i = 0; i < 16; i++) push(1'b1, 8'h61 + 8'(i));
        drain_and_compare("line16");
        chk("line16_row1", {30'd0, cur_row}, 32'd1);
        push(1'b1, 8'h7A);
        drain_and_compare("line17");

        // FIFO fill while a command keeps the FSM busy: ninth byte refused
        do_reset();
        push(1'b0, 8'h06);
        for (int i = 0; i < 9; i++) begin
            offer(1'b1, 8'h30 + 8'(i), acc);
            chk($sformatf("fill_ready%0d", i), {31'd0, acc}, (i < 8) ? 32'd1 : 32'd0);
        end
        drain_and_compare("fill");

        // Clear mid-line
        do_reset();
        for (int i = 0; i < 5; i++) push(1'b1, 8'h30 + 8'(i));
        drain_and_compare("pre_clear");
        measure_settle(1'b0, 8'h01, n);
        chk("settle_cmd", n, 8);
        drain_and_compare("clear");

        // Reset while E is high, with another byte still queued
        do_reset();
        push(1'b1, 8'h5A);
        push(1'b1, 8'h59);
        n = 0;
        while (!E_lcd && n < 50) begin @(negedge clk_1024); n++; end
        chk("strobe_seen", {31'd0, E_lcd}, 32'd1);
        mon_en  = 1'b0;
        reset_n = 1'b0;
        @(negedge clk_1024);
        chk("abort_e", {31'd0, E_lcd}, 32'd0);
        chk("abort_rs", {31'd0, RS_lcd}, 32'd1);
        chk("abort_data", {24'd0, data_lcd}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        q_obs.delete();
        q_exp.delete();
        m_col = 0; m_row = 0;
        mon_en = 1'b1;
        repeat (20) @(negedge clk_1024);
        chk("abort_no_write", q_obs.size(), 0);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        // 32 characters on two rows: second wrap returns to row 0
        do_reset();
        for (int i = 0; i < 32; i++) push(1'b1, 8'h40 + 8'(i));
        drain_and_compare("two_lines");

        // Randomized stream with random gaps
        do_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) push(1'b1, 8'($urandom_range(32'h20, 32'h7E)));
            else push(1'b0, cmds[$urandom_range(0, 3)]);
            repeat ($urandom_range(0, 3)) @(negedge clk_1024);
        end
        drain_and_compare("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
